// File: rtl/seq_divide_pkg.sv
// Shared types for the sequential divider: FSM state encoding and default operand width.
package seq_divide_pkg;

    localparam int DIV_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_divide_step.sv
// Combinational compare-and-subtract used by every divider iteration.
module seq_divide_step
    import seq_divide_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] div_i,
    output logic             ge_o,
    output logic [WIDTH-1:0] diff_o
);

    assign ge_o   = (rem_i >= div_i);
    assign diff_o = rem_i - div_i;

endmodule

// File: rtl/seq_divide.sv
// Sequential unsigned divider with a four-phase start/ack handshake.
// SEQ_DIVIDE_SHIFT_EN selects restoring shift-subtract (W+1 cycle latency) over repeated subtraction.
module seq_divide
    import seq_divide_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div0,
    output logic         ack
);

    state_t       state_q;
    logic [W-1:0] y_q;
    logic [W-1:0] quotient_q;
    logic [W-1:0] remainder_q;
    logic         div0_q;
    logic         ack_q;
    logic         primed_q;
    logic         y_zero_q;

`ifdef SEQ_DIVIDE_SHIFT_EN
    localparam int            CW       = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    logic [W-1:0]  x_q;
    logic [CW-1:0] cnt_q;
    logic [W:0]    partial;
    logic [W:0]    step_diff;
    logic [W:0]    rem_next;
    logic          step_ge;
    logic          unused_rem_msb;

    // Partial remainder is always below the divisor, so the shifted value fits in W+1 bits.
    assign partial = {remainder_q, x_q[cnt_q]};

    seq_divide_step #(.WIDTH(W + 1)) u_step (
        .rem_i  (partial),
        .div_i  ({1'b0, y_q}),
        .ge_o   (step_ge),
        .diff_o (step_diff)
    );

    assign rem_next       = step_ge ? step_diff : partial;
    assign unused_rem_msb = rem_next[W];
`else
    logic [W-1:0] step_diff;
    logic         step_ge;

    seq_divide_step #(.WIDTH(W)) u_step (
        .rem_i  (remainder_q),
        .div_i  (y_q),
        .ge_o   (step_ge),
        .diff_o (step_diff)
    );
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= IDLE;
            y_q         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div0_q      <= 1'b0;
            ack_q       <= 1'b0;
            primed_q    <= 1'b0;
            y_zero_q    <= 1'b0;
`ifdef SEQ_DIVIDE_SHIFT_EN
            x_q         <= '0;
            cnt_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    ack_q <= 1'b0;
                    if (start) begin
                        y_q         <= b;
                        quotient_q  <= '0;
                        remainder_q <= a;
                        div0_q      <= 1'b0;
                        primed_q    <= 1'b0;
                        state_q     <= RUN;
`ifdef SEQ_DIVIDE_SHIFT_EN
                        x_q         <= a;
`endif
                    end
                end
                RUN: begin
                    // First RUN cycle only registers the zero-divisor flag, keeping it off the capture path.
                    if (!primed_q) begin
                        primed_q <= 1'b1;
                        y_zero_q <= (y_q == '0);
`ifdef SEQ_DIVIDE_SHIFT_EN
                        cnt_q    <= CNT_LAST;
                        if (y_q != '0) begin
                            remainder_q <= '0;
                        end
`endif
                    end else if (y_zero_q) begin
                        div0_q     <= 1'b1;
                        quotient_q <= '1;
                        ack_q      <= 1'b1;
                        state_q    <= DONE;
                    end else begin
`ifdef SEQ_DIVIDE_SHIFT_EN
                        remainder_q        <= rem_next[W-1:0];
                        quotient_q[cnt_q]  <= step_ge;
                        cnt_q              <= cnt_q - 1'b1;
                        if (cnt_q == '0) begin
                            ack_q   <= 1'b1;
                            state_q <= DONE;
                        end
`else
                        if (step_ge) begin
                            remainder_q <= step_diff;
                            quotient_q  <= quotient_q + 1'b1;
                        end else begin
                            ack_q   <= 1'b1;
                            state_q <= DONE;
                        end
`endif
                    end
                end
                DONE: begin
                    if (!start) begin
                        ack_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div0      = div0_q;
    assign ack       = ack_q;

endmodule

// File: tb/tb_seq_divide.sv
// Self-checking bench for seq_divide: directed cases plus all 256 operand pairs in shuffled order.
module tb_seq_divide;

`ifdef SEQ_DIVIDE_SHIFT_EN
    localparam bit SHIFT = 1'b1;
`else
    localparam bit SHIFT = 1'b0;
`endif

    logic       Clk;
    logic       Rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div0;
    logic       ack;

    seq_divide #(.W(4)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .quotient  (quotient),
        .remainder (remainder),
        .div0      (div0),
        .ack       (ack)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Expected view of the outputs, maintained by the stimulus process.
    bit         checking   = 1'b0;
    bit         meaningful = 1'b0;
    bit         model_ack  = 1'b0;
    logic [3:0] model_q    = '0;
    logic [3:0] model_r    = '0;
    logic       model_d0   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (checking) begin
            chk("ack", int'(ack), int'(model_ack));
            if (meaningful) begin
                chk("quotient", int'(quotient), int'(model_q));
                chk("remainder", int'(remainder), int'(model_r));
                chk("div0", int'(div0), int'(model_d0));
            end
        end
    end

    // Reference: plain integer division; latency counted from the accepting edge.
    task automatic model_div(input logic [3:0] av, input logic [3:0] bv,
                             output logic [3:0] q, output logic [3:0] r,
                             output logic d0, output int lat);
        if (bv == 4'd0) begin
            q = 4'hF; r = av; d0 = 1'b1; lat = 2;
        end else begin
            q = av / bv; r = av % bv; d0 = 1'b0;
            lat = SHIFT ? 5 : int'(q) + 2;
        end
    endtask

    task automatic run_op(input logic [3:0] av, input logic [3:0] bv,
                          input logic [3:0] eq, input logic [3:0] er, input logic ed,
                          input int lat, input int hold, input bit zero_after);
        @(negedge Clk);
        a = av; b = bv; start = 1'b1;
        @(posedge Clk);
        #1;
        meaningful = 1'b0;
        model_ack  = 1'b0;
        if (zero_after) begin
            a = 4'd0; b = 4'd0;
        end else begin
            a = 4'($urandom); b = 4'($urandom);
        end
        repeat (lat) @(posedge Clk);
        #1;
        model_ack  = 1'b1;
        meaningful = 1'b1;
        model_q    = eq;
        model_r    = er;
        model_d0   = ed;
        repeat (hold) @(posedge Clk);
        @(negedge Clk);
        start = 1'b0;
        @(posedge Clk);
        #1;
        model_ack = 1'b0;
        $display("op a=%0d b=%0d expect q=%0d r=%0d div0=%0d lat=%0d hold=%0d", av, bv, eq, er, ed, lat, hold);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            a = 4'($urandom); b = 4'($urandom);
        end
    endtask

    int order [256];

    initial begin
        logic [3:0] q, r;
        logic       d0;
        int         lat;
        int         j, tmp;

        Rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge Clk);
        #1;
        meaningful = 1'b1; model_ack = 1'b0;
        model_q = '0; model_r = '0; model_d0 = 1'b0;
        checking = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        idle_cycles(2);

        // Directed cases with hand-computed expectations.
        run_op(4'd13, 4'd4, 4'd3, 4'd1, 1'b0, 5, 0, 1'b0);
        idle_cycles(1);
        run_op(4'd12, 4'd0, 4'd15, 4'd12, 1'b1, 2, 0, 1'b0);
        idle_cycles(1);
        run_op(4'd3, 4'd7, 4'd0, 4'd3, 1'b0, SHIFT ? 5 : 2, 0, 1'b0);
        idle_cycles(1);
        run_op(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, SHIFT ? 5 : 17, 0, 1'b1);
        idle_cycles(2);

        // Abort mid-computation with reset.
        @(negedge Clk);
        a = 4'd15; b = 4'd1; start = 1'b1;
        @(posedge Clk);
        #1;
        meaningful = 1'b0; model_ack = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b1; start = 1'b0;
        @(posedge Clk);
        #1;
        model_q = '0; model_r = '0; model_d0 = 1'b0; meaningful = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        idle_cycles(20);
        $display("op reset abort during 15/1");
        run_op(4'd9, 4'd3, 4'd3, 4'd0, 1'b0, 5, 0, 1'b0);

        // Start held through DONE must not launch a second operation.
        run_op(4'd10, 4'd3, 4'd3, 4'd1, 1'b0, 5, 5, 1'b0);
        idle_cycles(1);

        // All operand pairs, shuffled, with random hold and gap lengths.
        for (int i = 0; i < 256; i++) order[i] = i;
        for (int i = 255; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            tmp = order[i]; order[i] = order[j]; order[j] = tmp;
        end
        for (int i = 0; i < 256; i++) begin
            model_div(4'(order[i] >> 4), 4'(order[i]), q, r, d0, lat);
            run_op(4'(order[i] >> 4), 4'(order[i]), q, r, d0, lat,
                   int'($urandom_range(2, 0)), 1'b0);
            idle_cycles(int'($urandom_range(2, 0)));
        end

        idle_cycles(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_divide.md
Name: seq_divide

Overview:
- Sequential unsigned integer divider; the inverse of the team's repeated-addition multiplier.
- Computes quotient and remainder of a W-bit dividend by a W-bit divisor using repeated subtraction.
- Uses the same start/ack handshake, tightened to a full four-phase protocol.
- Sits beside the multiplier as an arithmetic slave driven by a controller or testbench.

Parameters:
W, 4, operand width in bits (dividend, divisor, quotient, remainder)

Ports:
Clk  in  1  system clock; all state changes on rising edge
Rst  in  1  synchronous reset, active-high
start  in  1  request; four-phase handshake with ack
a  in  W  dividend; sampled only when request accepted
b  in  W  divisor; sampled only when request accepted
quotient  out  W  a / b; valid while ack=1
remainder  out  W  a % b; valid while ack=1
div0  out  1  divisor was zero; valid while ack=1
ack  out  1  result ready

Behaviour:
- Clocking and reset:
  - One clock, Clk.
  - Rst is synchronous and active-high.
  - On reset: state=IDLE; quotient=0, remainder=0, div0=0, ack=0.
  - Rst overrides everything, including mid-computation; the operation is aborted and no ack is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - ack=0.
  - If start=1, capture x<=a, y<=b, quotient<=0, remainder<=a, div0<=0, then go to RUN.
  - If start=0, stay in IDLE.
- RUN (repeated-subtraction mode):
  - If y==0: div0<=1, quotient<=all ones, remainder unchanged (=a), ack<=1, go to DONE.
  - Else if remainder>=y: remainder<=remainder-y, quotient<=quotient+1, stay in RUN.
  - Else: ack<=1, go to DONE.
- DONE:
  - Outputs held stable.
  - While start=1, stay in DONE with ack=1.
  - When start=0: ack<=0, go to IDLE.
- Latency (start sampled at edge k):
  - ack=1 after edge k+q+2, where q is the quotient.
  - div-by-zero: ack after edge k+2.
  - Worst case with W=4: a=15, b=1, 17 cycles.
- Operand isolation:
  - a and b may change freely after the accepting edge.
  - start is ignored in RUN.
- Restart rule:
  - A new request is accepted only from IDLE.
  - start must drop and ack must fall before the next start is seen.
  - start held high continuously yields exactly one operation.
- Arithmetic:
  - All unsigned, W bits.
  - Compare and subtract are W-bit.
  - remainder<y is guaranteed in DONE unless div0=1.
  - quotient never wraps, since q<=2^W-1.
- Results persist after returning to IDLE until the next accepted request or reset.

Optional Feature:
- Macro: SEQ_DIVIDE_SHIFT_EN.
- Defined:
  - RUN uses restoring shift-subtract, one quotient bit per cycle, MSB first, with an internal W-bit iteration counter.
  - Data-independent latency: ack after edge k+W+1.
  - Divisor zero still exits after edge k+2 with the same div0 results.
  - Results are bit-identical to the undefined build.
- Undefined: repeated-subtraction behaviour as above.
- Port list identical in both builds.

Decomposition:
- Package seq_divide_pkg:
  - state encoding constants IDLE=0, RUN=1, DONE=2 (2-bit state register);
  - default width constant DIV_W=4.
- Sub-module seq_divide_step:
  - combinational compare-and-subtract;
  - inputs: partial remainder, divisor;
  - outputs: ge flag, difference;
  - used by both RUN variants;
  - W-parameterised.

Test Plan:
- Reset, then a=13, b=4, start=1 for one cycle then held until ack:
  - ack rises 5 cycles after the accepting edge;
  - quotient=3, remainder=1, div0=0.
- a=12, b=0:
  - ack after 2 cycles;
  - div0=1, quotient=15, remainder=12;
  - drop start -> ack=0 next edge, state IDLE.
- a=3, b=7:
  - quotient=0, remainder=3, ack after 2 cycles.
- a=15, b=1, then change a/b to 0 on the cycle after acceptance:
  - quotient=15, remainder=0 after 17 cycles;
  - results unaffected by the input change.
- Assert Rst mid-RUN during 15/1:
  - next edge all outputs 0, ack never rises;
  - new request 9/3 after reset gives quotient=3, remainder=0.
- Handshake:
  - hold start high through DONE for 5 cycles -> ack stays 1, no second operation;
  - exhaustive all 256 pairs (W=4) against a reference model in both macro builds; SEQ_DIVIDE_SHIFT_EN latency fixed at 5 for b!=0.
